// File: rtl/dp_ram_be.sv
// dp_ram_be: simple dual-port RAM, byte-enable writes on W_CK, pipelined
// reads on R_CK, and a write-side sequencer that zeroes the whole array.
`timescale 1ns/1ps
module dp_ram_be #(
  parameter int unsigned C_DAT_W      = 72,
  parameter int unsigned C_ADR_W      = 10,
  parameter int unsigned C_LANE_W     = 8,
  parameter int unsigned C_RD_LAT     = 1,
  parameter int unsigned C_CLR_ON_RST = 1,
  localparam int unsigned C_BE_W      = C_DAT_W / C_LANE_W
) (
  input  logic               W_CK_i,
  input  logic               R_CK_i,
  input  logic               XARST_i,
  input  logic               WE_i,
  input  logic [C_BE_W-1:0]  WBEs_i,
  input  logic [C_ADR_W-1:0] WAs_i,
  input  logic [C_DAT_W-1:0] WDs_i,
  input  logic               CLR_REQ_i,
  output logic               CLR_BUSY_o,
  input  logic               RE_i,
  input  logic [C_ADR_W-1:0] RAs_i,
  output logic [C_DAT_W-1:0] RDs_o,
  output logic               RD_VLD_o
);

  localparam int unsigned C_DEPTH = 2 ** C_ADR_W;
  localparam int unsigned C_CNT_W = C_ADR_W + 1;

  typedef enum logic {ST_IDLE, ST_CLR} state_t;

  logic [C_DAT_W-1:0] mem [C_DEPTH];

  state_t             st_q, st_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               rst_pend_q;

  logic               s1_we_q, s1_we_d;
  logic [C_BE_W-1:0]  s1_be_q, s1_be_d;
  logic [C_ADR_W-1:0] s1_adr_q, s1_adr_d;
  logic [C_DAT_W-1:0] s1_dat_q, s1_dat_d;

  logic               re_q;
  logic [C_ADR_W-1:0] ra_q;
  logic [C_RD_LAT-1:0] rd_vld_q;
  logic [C_DAT_W-1:0] rd_dat_q [C_RD_LAT];

  // One-shot flag that launches the post-reset clear on the first edge after release
  always_ff @(posedge W_CK_i or negedge XARST_i) begin
    if (!XARST_i) rst_pend_q <= 1'(C_CLR_ON_RST);
    else          rst_pend_q <= 1'b0;
  end

  // Clear FSM, counter, busy flag and write stage 1 registers
  always_ff @(posedge W_CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      s1_we_q  <= 1'b0;
      s1_be_q  <= '0;
      s1_adr_q <= '0;
      s1_dat_q <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      s1_we_q  <= s1_we_d;
      s1_be_q  <= s1_be_d;
      s1_adr_q <= s1_adr_d;
      s1_dat_q <= s1_dat_d;
    end
  end

  // Next state; stage 1 takes user writes when idle and clear words when clearing
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    s1_we_d  = WE_i & ~busy_q;
    s1_be_d  = WBEs_i;
    s1_adr_d = WAs_i;
    s1_dat_d = WDs_i;
    case (st_q)
      ST_IDLE: begin
        if (CLR_REQ_i || rst_pend_q) begin
          st_d   = ST_CLR;
          cnt_d  = '0;
          busy_d = 1'b1;
        end
      end
      ST_CLR: begin
        s1_we_d  = 1'b1;
        s1_be_d  = '1;
        s1_adr_d = cnt_q[C_ADR_W-1:0];
        s1_dat_d = '0;
        cnt_d    = C_CNT_W'(cnt_q + 1'b1);
        // Carry-out of the counter marks the last address loaded
        if (cnt_d[C_ADR_W]) begin
          st_d   = ST_IDLE;
          cnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Array commit: only enabled lanes are updated
  always_ff @(posedge W_CK_i) begin
    if (s1_we_q) begin
      for (int n = 0; n < int'(C_BE_W); n++) begin
        if (s1_be_q[n]) mem[s1_adr_q][n*C_LANE_W +: C_LANE_W] <= s1_dat_q[n*C_LANE_W +: C_LANE_W];
      end
    end
  end

  // Read request register, array read and valid-qualified output pipeline
  always_ff @(posedge R_CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      re_q     <= 1'b0;
      ra_q     <= '0;
      rd_vld_q <= '0;
      for (int i = 0; i < int'(C_RD_LAT); i++) rd_dat_q[i] <= '0;
    end else begin
      re_q        <= RE_i;
      ra_q        <= RAs_i;
      rd_vld_q[0] <= re_q;
      if (re_q) rd_dat_q[0] <= mem[ra_q];
      for (int i = 1; i < int'(C_RD_LAT); i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        if (rd_vld_q[i-1]) rd_dat_q[i] <= rd_dat_q[i-1];
      end
    end
  end

  assign CLR_BUSY_o = busy_q;
  assign RDs_o      = rd_dat_q[C_RD_LAT-1];
  assign RD_VLD_o   = rd_vld_q[C_RD_LAT-1];

endmodule

// File: doc/dp_ram_be.md
# dp_ram_be

Simple dual-port RAM with independent write and read clocks. It adds per-lane byte-enable writes, a read-enable with a valid strobe, a configurable read pipeline depth, and a hardware clear sequencer that zeroes the whole array on request or after reset. It is the general-purpose buffer for line/character stores crossing from the write-clock domain to the read-clock domain.

## Interface
- C_DAT_W, 72: data width; must be a multiple of C_LANE_W
- C_ADR_W, 10: address width; depth = 2**C_ADR_W
- C_LANE_W, 8: bits per byte-enable lane; lane count C_BE_W = C_DAT_W/C_LANE_W
- C_RD_LAT, 1: extra read output register stages, legal 1..4
- C_CLR_ON_RST, 1: 1 = start a full clear automatically after reset release

Ports:
- W_CK_i  in  1  write clock; write path and clear sequencer
- R_CK_i  in  1  read clock; read path
- XARST_i  in  1  reset, asynchronous, active-low
- WE_i  in  1  write request (W_CK)
- WBEs_i  in  C_BE_W  lane enables; bit n enables WDs_i[n*C_LANE_W +: C_LANE_W]
- WAs_i  in  C_ADR_W  write address
- WDs_i  in  C_DAT_W  write data
- CLR_REQ_i  in  1  clear request (W_CK, level-sampled)
- CLR_BUSY_o  out  1  clear in progress (W_CK)
- RE_i  in  1  read request (R_CK)
- RAs_i  in  C_ADR_W  read address
- RDs_o  out  C_DAT_W  read data (R_CK)
- RD_VLD_o  out  1  one-cycle strobe: RDs_o holds new read data (R_CK)

## Operation
- Reset: all registers clear. CLR_BUSY_o=0, RDs_o=0, RD_VLD_o=0, clear counter=0, FSM=IDLE. Reset does not initialise array contents.
- Write stage 1: at edge k, {WE_i & ~CLR_BUSY, WBEs_i, WAs_i, WDs_i} are registered. At edge k+1, enabled lanes are written; disabled lanes keep their old value. WE with WBEs=0 is a no-op.
- Clear FSM (W_CK):
  - States are IDLE and CLR.
  - IDLE->CLR when CLR_REQ_i=1 is sampled at edge k, or at the first edge after reset release when C_CLR_ON_RST=1. CLR_BUSY_o rises after edge k.
  - In CLR, stage 1 is loaded with {addr=i, all lanes, data 0} at edges k+1+i, for i = 0..2**C_ADR_W-1.
  - CLR->IDLE after the load at edge k+2**C_ADR_W. CLR_BUSY_o is therefore high for exactly 2**C_ADR_W W_CK cycles, and the last array clear commits at edge k+2**C_ADR_W+1.
  - CLR_REQ_i is ignored while in CLR. No queuing, no restart.
- A user write sampled at edge k (same edge as the clear request) is accepted and commits at k+1, before address 0 is cleared.
- User writes sampled while CLR_BUSY_o=1 are dropped silently.
- Counter wrap: the clear counter is C_ADR_W+1 bits wide, so termination is by carry-out. Depth 2**C_ADR_W is fully covered.
- Read path (R_CK):
  - At edge r, RE_i and RAs_i are registered.
  - At edge r+1 the array is read into output stage 0 if RE was set.
  - Stages 1..C_RD_LAT-1 forward data together with a valid bit.
  - The final stage drives RDs_o and RD_VLD_o.
  - Each data stage loads only when its incoming valid bit is 1, so RDs_o holds the last read value between strobes.
- Back-to-back reads, one per R_CK, are fully pipelined.
- Reads are allowed during a clear. Data is 0 only for addresses already committed by the clear; other addresses are undefined.
- Read/write collision:
  - Same address, with the write commit within one R_CK period of the array-read edge: returned data is undefined, either old or new.
  - With W_CK and R_CK tied to the same clock, a commit on the same edge as the array read returns the old data (read-first).
- Reset mid-operation aborts the clear, leaving the array partially cleared. Pipelines flush with RD_VLD_o=0. If C_CLR_ON_RST=1, a new full clear starts after release.

## Timing
- Write latency: 2 W_CK edges from WE_i sampled to data visible in the array (sample + commit).
- Read latency: 1+C_RD_LAT R_CK edges from RE_i sampled to RD_VLD_o/RDs_o. Default is 2.
- Clear: 2**C_ADR_W W_CK cycles busy. The first user write accepted after clear is at the edge following CLR_BUSY_o fall.
- No combinational path from any input to any output. All outputs are registered.
- No clock-domain synchronisers are included: CLR_BUSY_o is W_CK-domain and must be synchronised by the consumer if it is used in R_CK.

## Test plan
- Reset release with C_CLR_ON_RST=1, C_ADR_W=4 -> CLR_BUSY_o high for exactly 16 W_CK. Then reading addresses 0..15 returns all 0, RD_VLD_o pulses 16 times at latency 2.
- Write 0x..FF_FF at addr 5, then write with WBEs=0x01 and data 0x..00_12 -> read addr 5 returns 0x..FF_12 (other lanes unchanged).
- C_RD_LAT=3, RE held 4 cycles on addresses 1,2,3,4 -> RD_VLD_o high 4 consecutive cycles, starting 4 edges after the first RE. RDs_o holds the addr-4 data afterwards.
- CLR_REQ_i and WE_i (addr 0, data 0xAA) on the same edge -> addr 0 reads 0 after clear. WE_i during CLR_BUSY_o to addr 3 -> addr 3 reads 0. CLR_REQ_i re-pulsed mid-clear -> busy length unchanged.
- XARST_i asserted mid-clear and mid-read burst -> CLR_BUSY_o, RD_VLD_o, RDs_o = 0 immediately. After release, a full clear re-runs.
- Asynchronous clocks (W_CK 100 MHz, R_CK 37 MHz) running a random write/read scoreboard with collisions excluded -> zero mismatches.
